// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_pkg;

    // Lowest legal memory address; lower addresses are still passed through untouched.
    localparam logic [31:0] BASE_ADDR = 32'h8002_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10
    } arb_state_t;

    typedef enum logic [1:0] {
        SIZE_1W  = 2'b00,
        SIZE_4W  = 2'b01,
        SIZE_8W  = 2'b10,
        SIZE_16W = 2'b11
    } access_size_t;

    // Number of word beats in a burst of the given access size.
    function automatic logic [4:0] size_to_beats(input logic [1:0] size);
        case (size)
            SIZE_1W:  return 5'd1;
            SIZE_4W:  return 5'd4;
            SIZE_8W:  return 5'd8;
            default:  return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Beat address / beat count tracker for one burst, with last-beat detection.
module burst_counter
    import mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic [1:0]  load_size,
    input  logic        advance,
    output logic [31:0] addr,
    output logic        last
);

    logic [3:0] beat_cnt;
    logic [4:0] beats_q;

    // Load start address and length at grant, step one word per acknowledged beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr     <= 32'h0;
            beat_cnt <= 4'h0;
            beats_q  <= 5'd1;
        end else if (load) begin
            addr     <= load_addr;
            beat_cnt <= 4'h0;
            beats_q  <= size_to_beats(load_size);
        end else if (advance) begin
            addr     <= addr + 32'd4;    // wraps naturally modulo 2^32
            beat_cnt <= beat_cnt + 4'd1;
        end
    end

    assign last = ({1'b0, beat_cnt} == (beats_q - 5'd1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data bursts onto a single word-wide memory port.
// Data has priority, bounded by a starvation counter that forces an I grant.
module mem_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] BASE_ADDR    = mem_pkg::BASE_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_address,
    input  logic [1:0]  i_access_size,
    output logic        i_valid,
    output logic [31:0] i_data,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_address,
    input  logic [31:0] d_data_in,
    input  logic [1:0]  d_access_size,
    input  logic        d_byte,
    output logic        d_valid,
    output logic [31:0] d_data,
    output logic        d_stall,
    output logic        m_enable,
    output logic        m_rw,
    output logic        m_byte,
    output logic [31:0] m_address,
    output logic [31:0] m_data_in,
    output logic [1:0]  m_access_size,
    input  logic        m_ack,
    input  logic [31:0] m_data_out
);
    import mem_pkg::*;

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state, state_nxt;
    logic          grant_d, grant_i;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   addr;
    logic          last;
    logic          busy;

    assign busy = (state != IDLE);

    burst_counter u_burst (
        .clock     (clock),
        .reset     (reset),
        .load      (grant_d | grant_i),
        .load_addr (grant_d ? d_address : i_address),
        .load_size (grant_d ? d_access_size : i_access_size),
        .advance   (busy & m_ack),
        .addr      (addr),
        .last      (last)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Grant decision in IDLE; bursts run to their last acknowledged beat.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || starve_cnt < SW'(STARVE_LIMIT))) begin
                    grant_d   = 1'b1;
                    state_nxt = D_BUSY;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: if (m_ack && last) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    // Count D grants that bypass a waiting I request; saturate at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!i_req)                                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Memory strobes and requester responses, all zero while idle.
    always_comb begin
        m_enable  = 1'b0;
        m_rw      = 1'b0;
        m_byte    = 1'b0;
        m_address = 32'h0;
        m_data_in = 32'h0;
        i_valid   = 1'b0;
        i_data    = 32'h0;
        d_valid   = 1'b0;
        d_data    = 32'h0;
        case (state)
            I_BUSY: begin
                m_enable  = 1'b1;
                m_rw      = 1'b1;
                m_address = addr;
                i_valid   = m_ack;
                i_data    = m_ack ? m_data_out : 32'h0;
            end
            D_BUSY: begin
                m_enable  = 1'b1;
                m_rw      = d_rw;
                m_byte    = d_byte;
                m_address = addr;
                m_data_in = d_data_in;
                d_valid   = m_ack;
                d_data    = (m_ack && d_rw) ? m_data_out : 32'h0;
            end
            default: ;
        endcase
    end

    assign m_access_size = SIZE_1W;
    assign i_stall = i_req & ~(i_valid & last);
    assign d_stall = d_req & ~(d_valid & last);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_address;
    logic [1:0]  i_access_size;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_stall;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_address;
    logic [31:0] d_data_in;
    logic [1:0]  d_access_size;
    logic        d_byte;
    logic        d_valid;
    logic [31:0] d_data;
    logic        d_stall;
    logic        m_enable, m_rw, m_byte;
    logic [31:0] m_address, m_data_in;
    logic [1:0]  m_access_size;
    logic        m_ack;
    logic [31:0] m_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model: registered ack after wait_states enabled cycles, data from current address
    int   wait_states = 0;
    int   wcnt = 0;
    logic ack_q = 1'b0;
    logic ack_force = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!m_enable) begin
            ack_q <= 1'b0;
            wcnt  <= 0;
        end else if (wcnt >= wait_states) begin
            ack_q <= 1'b1;
            wcnt  <= 0;
        end else begin
            ack_q <= 1'b0;
            wcnt  <= wcnt + 1;
        end
    end

    assign m_ack      = ack_q | ack_force;
    assign m_data_out = m_ack ? mem_word(m_address) : 32'h0;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_access_size(i_access_size),
        .i_valid(i_valid), .i_data(i_data), .i_stall(i_stall),
        .d_req(d_req), .d_rw(d_rw), .d_address(d_address), .d_data_in(d_data_in),
        .d_access_size(d_access_size), .d_byte(d_byte),
        .d_valid(d_valid), .d_data(d_data), .d_stall(d_stall),
        .m_enable(m_enable), .m_rw(m_rw), .m_byte(m_byte),
        .m_address(m_address), .m_data_in(m_data_in), .m_access_size(m_access_size),
        .m_ack(m_ack), .m_data_out(m_data_out)
    );

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clock);
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock); #1;
        n_tests++;
        if ({m_enable, m_rw, m_byte, i_valid, d_valid, i_stall, d_stall} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000000",
                     {m_enable, m_rw, m_byte, i_valid, d_valid, i_stall, d_stall});
        end
        n_tests++;
        if ({m_address, m_data_in, i_data, d_data, m_access_size} !== 130'b0) begin
            n_fail++;
            $display("FAIL reset_buses: got addr %h wdata %h idata %h ddata %h size %b want all 0",
                     m_address, m_data_in, i_data, d_data, m_access_size);
        end
        @(negedge clock);
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_i_burst;
        logic [31:0] a0 = 32'h8002_0000;
        logic [31:0] ea;
        logic        ev, ee, es;
        @(negedge clock);
        i_req = 1'b1; i_address = a0; i_access_size = 2'b01;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            ev = (c >= 2 && c <= 5);
            ee = (c >= 1 && c <= 5);
            es = (c <= 4);
            ea = a0 + 32'(4 * ((c >= 2) ? c - 2 : 0));
            n_tests++;
            if (i_valid !== ev) begin
                n_fail++; $display("FAIL i_burst_valid c%0d: got %b want %b", c, i_valid, ev);
            end
            n_tests++;
            if (m_enable !== ee) begin
                n_fail++; $display("FAIL i_burst_enable c%0d: got %b want %b", c, m_enable, ee);
            end
            n_tests++;
            if (i_stall !== es) begin
                n_fail++; $display("FAIL i_burst_stall c%0d: got %b want %b", c, i_stall, es);
            end
            if (ee) begin
                n_tests++;
                if (m_address !== ea || m_rw !== 1'b1) begin
                    n_fail++;
                    $display("FAIL i_burst_addr c%0d: got %h rw %b want %h rw 1", c, m_address, m_rw, ea);
                end
            end
            if (ev) begin
                n_tests++;
                if (i_data !== mem_word(ea)) begin
                    n_fail++; $display("FAIL i_burst_data c%0d: got %h want %h", c, i_data, mem_word(ea));
                end
            end
            if (c == 5) i_req = 1'b0;
        end
        idle(2);
    endtask

    task automatic test_simultaneous;
        logic [31:0] da = 32'h8002_0100;
        logic [31:0] ia = 32'h8002_0200;
        @(negedge clock);
        d_req = 1'b1; d_rw = 1'b1; d_address = da; d_access_size = 2'b00;
        i_req = 1'b1; i_address = ia; i_access_size = 2'b00;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            n_tests++;
            if (d_valid !== (c == 2) || i_valid !== (c == 5)) begin
                n_fail++;
                $display("FAIL simul_valid c%0d: got d%b i%b want d%b i%b",
                         c, d_valid, i_valid, c == 2, c == 5);
            end
            if (c == 1 || c == 4) begin
                n_tests++;
                if (m_address !== ((c == 1) ? da : ia) || m_rw !== 1'b1) begin
                    n_fail++;
                    $display("FAIL simul_addr c%0d: got %h rw %b want %h rw 1",
                             c, m_address, m_rw, (c == 1) ? da : ia);
                end
            end
            if (c == 2) begin
                n_tests++;
                if (d_data !== mem_word(da) || i_stall !== 1'b1 || d_stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL simul_d_beat: got data %h istall %b dstall %b want %h 1 0",
                             d_data, i_stall, d_stall, mem_word(da));
                end
                d_req = 1'b0;
            end
            if (c == 5) begin
                n_tests++;
                if (i_data !== mem_word(ia)) begin
                    n_fail++; $display("FAIL simul_i_data: got %h want %h", i_data, mem_word(ia));
                end
                i_req = 1'b0;
            end
        end
        idle(2);
    endtask

    task automatic test_starvation;
        logic [7:0] got [8];
        logic [7:0] exp_seq [8] = '{"D", "D", "D", "D", "I", "D", "D", "D"};
        int n = 0;
        @(negedge clock);
        d_req = 1'b1; d_rw = 1'b1; d_address = 32'h8002_0300; d_access_size = 2'b00;
        i_req = 1'b1; i_address = 32'h8002_0400; i_access_size = 2'b00;
        #1;
        for (int c = 0; c < 60 && n < 8; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            if (d_valid) begin got[n] = "D"; n++; end
            else if (i_valid) begin got[n] = "I"; n++; end
            if (n == 8) begin d_req = 1'b0; i_req = 1'b0; end
        end
        n_tests++;
        if (n != 8) begin
            n_fail++; $display("FAIL starve_timeout: got %0d grants want 8", n);
            d_req = 1'b0; i_req = 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_tests++;
                if (got[k] !== exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL starve_order[%0d]: got %s want %s", k, got[k], exp_seq[k]);
                end
            end
        end
        idle(3);
    endtask

    task automatic test_byte_write;
        int nv = 0;
        @(negedge clock);
        d_req = 1'b1; d_rw = 1'b0; d_byte = 1'b1; d_address = 32'h8002_0003;
        d_data_in = 32'h0000_00A5; d_access_size = 2'b00;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            if (d_valid) nv++;
            if (c == 1) begin
                n_tests++;
                if ({m_enable, m_rw, m_byte} !== 3'b101 || m_data_in !== 32'h0000_00A5 ||
                    m_address !== 32'h8002_0003) begin
                    n_fail++;
                    $display("FAIL byte_write_strobe: got en/rw/byte %b data %h addr %h want 101 000000a5 80020003",
                             {m_enable, m_rw, m_byte}, m_data_in, m_address);
                end
            end
            if (c == 2) d_req = 1'b0;
            if (c == 4) begin
                n_tests++;
                if (m_byte !== 1'b0) begin
                    n_fail++; $display("FAIL byte_idle: got m_byte %b want 0", m_byte);
                end
            end
        end
        n_tests++;
        if (nv != 1) begin
            n_fail++; $display("FAIL byte_write_valids: got %0d want 1", nv);
        end
        d_byte = 1'b0; d_rw = 1'b1; d_data_in = 32'h0;
        idle(2);
    endtask

    task automatic test_reset_mid_burst;
        @(negedge clock);
        d_req = 1'b1; d_rw = 1'b1; d_address = 32'h8002_0800; d_access_size = 2'b10;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            if (c >= 2 && c <= 4) begin
                n_tests++;
                if (d_valid !== 1'b1) begin
                    n_fail++; $display("FAIL rst_burst_pre c%0d: got d_valid %b want 1", c, d_valid);
                end
            end
            if (c >= 5) begin
                n_tests++;
                if (d_valid !== 1'b0 || m_enable !== 1'b0 || m_address !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rst_burst_post c%0d: got valid %b en %b addr %h want 0 0 0",
                             c, d_valid, m_enable, m_address);
                end
            end
            if (c == 4) reset = 1'b1;
            if (c == 5) begin reset = 1'b0; d_req = 1'b0; ack_force = 1'b1; end
            if (c == 6) ack_force = 1'b0;
        end
        d_access_size = 2'b00;
        idle(2);
    endtask

    task automatic test_wait_states;
        logic [31:0] a0 = 32'h8002_0040;
        logic [31:0] ea;
        logic        ev;
        wait_states = 3;
        @(negedge clock);
        d_req = 1'b1; d_rw = 1'b1; d_address = a0; d_access_size = 2'b01;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            ev = (c == 5 || c == 9 || c == 13 || c == 17);
            ea = a0 + 32'(4 * ((c >= 2) ? (c - 2) / 4 : 0));
            n_tests++;
            if (d_valid !== ev || d_stall !== (c < 17)) begin
                n_fail++;
                $display("FAIL wait_valid_stall c%0d: got v%b s%b want v%b s%b",
                         c, d_valid, d_stall, ev, c < 17);
            end
            if (c >= 1 && c <= 17) begin
                n_tests++;
                if (m_enable !== 1'b1 || m_address !== ea) begin
                    n_fail++;
                    $display("FAIL wait_hold c%0d: got en %b addr %h want 1 %h", c, m_enable, m_address, ea);
                end
            end
            if (ev) begin
                n_tests++;
                if (d_data !== mem_word(ea)) begin
                    n_fail++; $display("FAIL wait_data c%0d: got %h want %h", c, d_data, mem_word(ea));
                end
            end
            if (c == 17) d_req = 1'b0;
        end
        wait_states = 0;
        d_access_size = 2'b00;
        idle(2);
    endtask

    task automatic test_wrap_16;
        logic [31:0] a0 = 32'hFFFF_FFE0;
        logic [31:0] ea;
        int nv = 0;
        @(negedge clock);
        i_req = 1'b1; i_address = a0; i_access_size = 2'b11;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            if (i_valid) begin
                ea = a0 + 32'(4 * nv);
                n_tests++;
                if (m_address !== ea || i_data !== mem_word(ea)) begin
                    n_fail++;
                    $display("FAIL wrap_beat%0d: got addr %h data %h want %h %h",
                             nv, m_address, i_data, ea, mem_word(ea));
                end
                nv++;
            end
            if (c == 17) begin
                n_tests++;
                if (i_valid !== 1'b1 || i_stall !== 1'b0) begin
                    n_fail++; $display("FAIL wrap_last: got valid %b stall %b want 1 0", i_valid, i_stall);
                end
                i_req = 1'b0;
            end
        end
        n_tests++;
        if (nv != 16) begin
            n_fail++; $display("FAIL wrap_count: got %0d want 16", nv);
        end
        i_access_size = 2'b00;
        idle(2);
    endtask

    initial begin
        reset = 1'b0;
        i_req = 1'b0; i_address = 32'h0; i_access_size = 2'b00;
        d_req = 1'b0; d_rw = 1'b1; d_address = 32'h0; d_data_in = 32'h0;
        d_access_size = 2'b00; d_byte = 1'b0;
        test_reset();
        test_i_burst();
        test_simultaneous();
        test_starvation();
        test_byte_write();
        test_reset_mid_burst();
        test_wait_states();
        test_wrap_16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive D grants while I waits.
REQ-002 Parameter BASE_ADDR, default 32'h80020000, lowest legal address; requests below it are still forwarded unmodified.
REQ-003 clock  in  1  rising-edge clock; the block uses one clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_req  in  1  fetch request, held until the last i_valid.
REQ-006 i_address  in  32  fetch start address, word-aligned.
REQ-007 i_access_size  in  2  burst length: 00=1, 01=4, 10=8, 11=16 words.
REQ-008 i_valid  out  1  fetch beat data valid.
REQ-009 i_data  out  32  fetch beat data.
REQ-010 i_stall  out  1  i_req & ~(i_valid on last beat).
REQ-011 d_req  in  1  data request, held until the last d_valid.
REQ-012 d_rw  in  1  1=read, 0=write.
REQ-013 d_address  in  32  data start address.
REQ-014 d_data_in  in  32  write data, sampled on every beat.
REQ-015 d_access_size  in  2  same encoding as i_access_size.
REQ-016 d_byte  in  1  byte access; legal only with size 00.
REQ-017 d_valid  out  1  data beat complete (read data valid or write accepted).
REQ-018 d_data  out  32  read beat data.
REQ-019 d_stall  out  1  d_req & ~(d_valid on last beat).
REQ-020 m_enable, m_rw, m_byte  out  1 each  memory strobe, direction, byte mode.
REQ-021 m_address, m_data_in  out  32 each  beat address and write data.
REQ-022 m_access_size  out  2  always 00, because each beat is one word.
REQ-023 m_ack  in  1  one-cycle beat-complete pulse from memory.
REQ-024 m_data_out  in  32  read data, valid while m_ack=1.

Function
REQ-025 FSM states: IDLE, I_BUSY, D_BUSY.
REQ-026 IDLE→D_BUSY when d_req & (~i_req | starve_cnt<STARVE_LIMIT); when d_req and i_req are simultaneous, D wins under that condition.
REQ-027 IDLE→I_BUSY when i_req and D_BUSY was not taken.
REQ-028 At the grant edge: beat_cnt←0 and addr←requester address; m_enable=1 from the next cycle.
REQ-029 Per beat: m_address=addr; m_enable stays high until m_ack; on m_ack, addr+=4, beat_cnt+=1, and valid is pulsed in the same cycle with data = m_data_out.
REQ-030 Last beat (beat_cnt==len-1 with m_ack) → IDLE with m_enable low; there is one idle turnaround cycle before any new grant.
REQ-031 Minimum latency from request to first valid is 2 cycles, given memory acks in the first enabled cycle.
REQ-032 starve_cnt: +1 on each D grant while i_req=1; cleared on an I grant or when i_req=0 at a D grant; saturates at STARVE_LIMIT.
REQ-033 Once granted, a burst always completes; requester deassertion mid-burst is illegal and ignored.
REQ-034 m_ack in IDLE is ignored and produces no valid.
REQ-035 addr wraps modulo 2^32.
REQ-036 i_* requests never write: m_rw=1 in I_BUSY.
REQ-037 m_byte=d_byte only in D_BUSY, otherwise 0.

Reset
REQ-038 reset forces IDLE, starve_cnt=0, beat_cnt=0, addr=0, and all outputs 0 at the next edge.
REQ-039 reset mid-burst abandons the burst: no further valid is issued, and late m_ack is ignored.

Structure
REQ-040 Shared package mem_pkg holds: FSM state encoding, access-size encoding, the function mapping size to beat count, and BASE_ADDR.
REQ-041 One sub-module, burst_counter, owns addr/beat_cnt/last-beat detection; the arbiter FSM instantiates it once.

Verification
REQ-042 I-only: i_req, addr 0x80020000, size 01, immediate acks → 4 i_valid on cycles 2-5, m_address 0x80020000..0x8002000C, i_stall low after beat 4.
REQ-043 Simultaneous: i_req and d_req read, size 00, at cycle 0 → D served first, I granted after the turnaround, d_valid precedes i_valid by 3 cycles.
REQ-044 Starvation: d_req continuously, single beats, i_req held → exactly 4 D grants, then 1 I grant, then D resumes.
REQ-045 Byte write: d_rw=0, d_byte=1, address 0x80020003, data 0x000000A5 → m_rw=0, m_byte=1, m_data_in=0x000000A5, d_valid once.
REQ-046 Reset at beat 2 of a 8-beat burst → m_enable low the next cycle, no further valid, and a later m_ack pulse is ignored.
REQ-047 Wait states: m_ack delayed 3 cycles per beat → m_enable and m_address held stable and d_stall high throughout.
